// File: rtl/axis_to_data_inf.sv
// AXI-stream to data_inf converter: a two-entry skid buffer feeding a registered
// data_inf output, with an optional length-marker beat appended after each frame.
module axis_to_data_inf #(
    parameter int unsigned DSIZE     = 32,
    parameter int unsigned LSIZE     = 24,
    parameter bit          TAIL_MARK = 1'b1
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [DSIZE-1:0] axis_tdata,
    input  logic             axis_tvalid,
    output logic             axis_tready,
    input  logic             axis_tlast,
    output logic [DSIZE-1:0] data,
    output logic             valid,
    input  logic             ready,
    output logic             last_flag,
    output logic             mark_curr_data,
    output logic [LSIZE-1:0] frame_len,
    output logic             overflow
);

    localparam logic [0:0] ST_STREAM = 1'b0;
    localparam logic [0:0] ST_MARK   = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [DSIZE-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             out_mark_q, out_mark_d;
    logic             out_tlast_q, out_tlast_d;
    logic [DSIZE-1:0] skid_data_q, skid_data_d;
    logic             skid_last_q, skid_last_d;
    logic             skid_valid_q, skid_valid_d;
    logic             tready_q, tready_d;
    logic [LSIZE-1:0] cnt_q, cnt_d;
    logic [LSIZE-1:0] frame_len_q, frame_len_d;
    logic             overflow_q, overflow_d;

    logic             out_hs_s, in_hs_s, pay_hs_s, end_hs_s, cnt_full_s;
    logic [LSIZE-1:0] cnt_inc_s;
    logic             src_valid_s, src_last_s;
    logic [DSIZE-1:0] src_data_s;
    logic             load_mark_s, load_src_s;

    function automatic logic [DSIZE-1:0] zext_len(input logic [LSIZE-1:0] v);
        logic [DSIZE-1:0] r;
        r          = {DSIZE{1'b0}};
        r[LSIZE-1:0] = v;
        return r;
    endfunction

    assign out_hs_s   = out_valid_q & ready;
    assign in_hs_s    = axis_tvalid & tready_q;
    assign pay_hs_s   = out_hs_s & ~out_mark_q;
    assign end_hs_s   = pay_hs_s & out_tlast_q;
    assign cnt_full_s = &cnt_q;
    // The count saturates so an oversized frame reports all-ones rather than wrapping.
    assign cnt_inc_s  = cnt_full_s ? cnt_q : cnt_q + {{(LSIZE-1){1'b0}}, 1'b1};

    // A buffered skid beat always precedes the live input beat.
    assign src_valid_s = skid_valid_q | in_hs_s;
    assign src_data_s  = skid_valid_q ? skid_data_q : axis_tdata;
    assign src_last_s  = skid_valid_q ? skid_last_q : axis_tlast;

    // Frame state machine: decides whether the output register takes a marker or a beat.
    always_comb begin
        state_d     = state_q;
        load_mark_s = 1'b0;
        load_src_s  = 1'b0;
        case (state_q)
            ST_STREAM: begin
                if (end_hs_s && TAIL_MARK) begin
                    load_mark_s = 1'b1;
                    state_d     = ST_MARK;
                end else if (!out_valid_q || out_hs_s) begin
                    load_src_s = 1'b1;
                end else begin
                    load_src_s = 1'b0;
                end
            end
            ST_MARK: begin
                if (out_hs_s) begin
                    load_src_s = 1'b1;
                    state_d    = ST_STREAM;
                end else begin
                    state_d = ST_MARK;
                end
            end
            default: begin
                state_d = ST_STREAM;
            end
        endcase
    end

    // Output and skid register next-state.
    always_comb begin
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_mark_d   = out_mark_q;
        out_tlast_d  = out_tlast_q;
        skid_data_d  = skid_data_q;
        skid_last_d  = skid_last_q;
        skid_valid_d = skid_valid_q;
        if (load_mark_s) begin
            out_data_d  = zext_len(cnt_inc_s);
            out_valid_d = 1'b1;
            out_last_d  = 1'b1;
            out_mark_d  = 1'b1;
            out_tlast_d = 1'b0;
        end else if (load_src_s) begin
            out_valid_d = src_valid_s;
            out_data_d  = src_data_s;
            out_tlast_d = src_last_s;
            out_last_d  = TAIL_MARK ? 1'b0 : src_last_s;
            out_mark_d  = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        // An input handshake implies the skid is empty, so loading never overwrites a beat.
        if (load_src_s) begin
            skid_valid_d = 1'b0;
        end else if (in_hs_s) begin
            skid_valid_d = 1'b1;
            skid_data_d  = axis_tdata;
            skid_last_d  = axis_tlast;
        end else begin
            skid_valid_d = skid_valid_q;
        end
        tready_d = ~skid_valid_d;
    end

    // Beat counter, completed-frame length and sticky overflow.
    always_comb begin
        cnt_d       = cnt_q;
        frame_len_d = frame_len_q;
        overflow_d  = overflow_q;
        if (pay_hs_s) begin
            if (out_tlast_q) begin
                cnt_d       = {LSIZE{1'b0}};
                frame_len_d = cnt_inc_s;
            end else begin
                cnt_d = cnt_inc_s;
            end
            if (cnt_full_s) begin
                overflow_d = 1'b1;
            end else begin
                overflow_d = overflow_q;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_STREAM;
            out_data_q   <= {DSIZE{1'b0}};
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_mark_q   <= 1'b0;
            out_tlast_q  <= 1'b0;
            skid_data_q  <= {DSIZE{1'b0}};
            skid_last_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            tready_q     <= 1'b0;
            cnt_q        <= {LSIZE{1'b0}};
            frame_len_q  <= {LSIZE{1'b0}};
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_mark_q   <= out_mark_d;
            out_tlast_q  <= out_tlast_d;
            skid_data_q  <= skid_data_d;
            skid_last_q  <= skid_last_d;
            skid_valid_q <= skid_valid_d;
            tready_q     <= tready_d;
            cnt_q        <= cnt_d;
            frame_len_q  <= frame_len_d;
            overflow_q   <= overflow_d;
        end
    end

    assign axis_tready    = tready_q;
    assign data           = out_data_q;
    assign valid          = out_valid_q;
    assign last_flag      = out_last_q;
    assign mark_curr_data = out_mark_q;
    assign frame_len      = frame_len_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_axis_to_data_inf.sv
// Directed bench for axis_to_data_inf: default, pass-through (TAIL_MARK=0) and
// narrow-counter (LSIZE=4) instances driven from one linear sequence.
module tb_axis_to_data_inf;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        aresetn;
    logic [31:0] tdata  [3];
    logic        tvalid [3];
    logic        tlast  [3];
    logic        tready [3];
    logic [31:0] odata  [3];
    logic        ovalid [3];
    logic        ordy   [3];
    logic        olast  [3];
    logic        omark  [3];
    logic        ovf    [3];
    logic [23:0] fl0, fl1;
    logic [3:0]  fl2;

    axis_to_data_inf dut0 (
        .aclk(clk), .aresetn(aresetn), .axis_tdata(tdata[0]), .axis_tvalid(tvalid[0]),
        .axis_tready(tready[0]), .axis_tlast(tlast[0]), .data(odata[0]), .valid(ovalid[0]),
        .ready(ordy[0]), .last_flag(olast[0]), .mark_curr_data(omark[0]),
        .frame_len(fl0), .overflow(ovf[0]));

    axis_to_data_inf #(.TAIL_MARK(1'b0)) dut1 (
        .aclk(clk), .aresetn(aresetn), .axis_tdata(tdata[1]), .axis_tvalid(tvalid[1]),
        .axis_tready(tready[1]), .axis_tlast(tlast[1]), .data(odata[1]), .valid(ovalid[1]),
        .ready(ordy[1]), .last_flag(olast[1]), .mark_curr_data(omark[1]),
        .frame_len(fl1), .overflow(ovf[1]));

    axis_to_data_inf #(.LSIZE(4)) dut2 (
        .aclk(clk), .aresetn(aresetn), .axis_tdata(tdata[2]), .axis_tvalid(tvalid[2]),
        .axis_tready(tready[2]), .axis_tlast(tlast[2]), .data(odata[2]), .valid(ovalid[2]),
        .ready(ordy[2]), .last_flag(olast[2]), .mark_curr_data(omark[2]),
        .frame_len(fl2), .overflow(ovf[2]));

    typedef struct { int s; logic [31:0] d; logic m; logic l; int c; } beat_t;
    typedef struct { logic [31:0] d; logic m; logic l; } exp_t;

    beat_t obs[$];
    beat_t gq[$];
    exp_t  ex[$];
    int    checks = 0;
    int    fails  = 0;
    int    cyc    = 0;
    int    in_cnt [3];
    int    low_cnt[3];
    logic        hold[3];
    logic [31:0] hd  [3];
    logic        hm  [3];
    logic        hl  [3];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: logs handshakes and checks the hold rule while stalled.
    always @(negedge clk) begin
        for (int s = 0; s < 3; s++) begin
            if (aresetn) begin
                if (hold[s]) begin
                    chk($sformatf("hold_valid%0d", s), 32'(ovalid[s]), 32'd1);
                    chk($sformatf("hold_data%0d", s), odata[s], hd[s]);
                    chk($sformatf("hold_mark%0d", s), 32'(omark[s]), 32'(hm[s]));
                    chk($sformatf("hold_last%0d", s), 32'(olast[s]), 32'(hl[s]));
                end
                if (ovalid[s] && ordy[s]) begin
                    beat_t b;
                    b.s = s; b.d = odata[s]; b.m = omark[s]; b.l = olast[s]; b.c = cyc;
                    obs.push_back(b);
                end
                if (tvalid[s] && tready[s]) in_cnt[s]++;
                if (!tready[s]) low_cnt[s]++;
                hold[s] = ovalid[s] && !ordy[s];
                hd[s] = odata[s]; hm[s] = omark[s]; hl[s] = olast[s];
            end else begin
                hold[s] = 1'b0;
            end
        end
    end

    task automatic send(input int s, input logic [31:0] base, input int n);
        int w;
        for (int i = 0; i < n; i++) begin
            tdata[s] = base + 32'(i); tlast[s] = (i == n - 1); tvalid[s] = 1'b1;
            w = 0;
            do begin @(negedge clk); w++; end while (!tready[s] && w < 200);
            if (!tready[s]) chk("send_timeout", 32'd0, 32'd1);
            @(posedge clk); #1;
        end
        tvalid[s] = 1'b0; tlast[s] = 1'b0;
    endtask

    task automatic ready_run(input int s, input logic [15:0] pat, input int n);
        for (int c = 0; c < n; c++) begin
            ordy[s] = pat[c % 16];
            @(posedge clk); #1;
        end
        ordy[s] = 1'b1;
    endtask

    task automatic add_frame(input logic [31:0] base, input int n, input bit tm, input logic [31:0] mval);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.d = base + 32'(i); e.m = 1'b0; e.l = tm ? 1'b0 : (i == n - 1);
            ex.push_back(e);
        end
        if (tm) begin
            e.d = mval; e.m = 1'b1; e.l = 1'b1;
            ex.push_back(e);
        end
    endtask

    task automatic compare(input int s, input string tag);
        gq.delete();
        foreach (obs[k]) if (obs[k].s == s) gq.push_back(obs[k]);
        chk({tag, "_count"}, 32'(gq.size()), 32'(ex.size()));
        for (int k = 0; k < ex.size() && k < gq.size(); k++) begin
            chk($sformatf("%s_data%0d", tag, k), gq[k].d, ex[k].d);
            chk($sformatf("%s_mark%0d", tag, k), 32'(gq[k].m), 32'(ex[k].m));
            chk($sformatf("%s_last%0d", tag, k), 32'(gq[k].l), 32'(ex[k].l));
        end
    endtask

    task automatic chk_reset(input int s, input string tag);
        chk({tag, "_tready"}, 32'(tready[s]), 32'd0);
        chk({tag, "_valid"}, 32'(ovalid[s]), 32'd0);
        chk({tag, "_data"}, odata[s], 32'd0);
        chk({tag, "_last"}, 32'(olast[s]), 32'd0);
        chk({tag, "_mark"}, 32'(omark[s]), 32'd0);
        chk({tag, "_ovf"}, 32'(ovf[s]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tdata[s] = 32'd0; tvalid[s] = 1'b0; tlast[s] = 1'b0; ordy[s] = 1'b0;
            in_cnt[s] = 0; low_cnt[s] = 0; hold[s] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 3; s++) chk_reset(s, $sformatf("rst%0d", s));
        chk("rst_fl0", 32'(fl0), 32'd0);
        chk("rst_fl2", 32'(fl2), 32'd0);
        @(posedge clk); #1;
        aresetn = 1'b1;
        @(negedge clk);
        chk("tready_before_clk", 32'(tready[0]), 32'd0);
        @(negedge clk);
        chk("tready_after_clk", 32'(tready[0]), 32'd1);
        @(posedge clk); #1;
        for (int s = 0; s < 3; s++) ordy[s] = 1'b1;

        // 4-beat frame, ready held high
        obs.delete(); ex.delete();
        fork
            send(0, 32'h10, 4);
            ready_run(0, 16'hFFFF, 12);
        join
        add_frame(32'h10, 4, 1'b1, 32'd4);
        compare(0, "t1");
        if (gq.size() >= 5) chk("t1_consec", 32'(gq[4].c - gq[0].c), 32'd4);
        else chk("t1_consec_missing", 32'(gq.size()), 32'd5);
        chk("t1_frame_len", 32'(fl0), 32'd4);

        // back-to-back single-beat frames
        obs.delete(); ex.delete(); low_cnt[0] = 0;
        fork
            begin send(0, 32'hA, 1); send(0, 32'hB, 1); end
            ready_run(0, 16'hFFFF, 12);
        join
        add_frame(32'hA, 1, 1'b1, 32'd1);
        add_frame(32'hB, 1, 1'b1, 32'd1);
        compare(0, "t2");
        if (gq.size() >= 4) chk("t2_consec", 32'(gq[3].c - gq[0].c), 32'd3);
        else chk("t2_consec_missing", 32'(gq.size()), 32'd4);
        chk("t2_tready_low_le2", 32'(low_cnt[0] <= 2), 32'd1);
        chk("t2_frame_len", 32'(fl0), 32'd1);

        // three frames against a fixed 50% ready pattern
        obs.delete(); ex.delete();
        fork
            begin send(0, 32'h100, 7); send(0, 32'h200, 1); send(0, 32'h300, 16); end
            ready_run(0, 16'b1010_0110_1100_1001, 120);
        join
        add_frame(32'h100, 7, 1'b1, 32'd7);
        add_frame(32'h200, 1, 1'b1, 32'd1);
        add_frame(32'h300, 16, 1'b1, 32'd16);
        compare(0, "t3");
        chk("t3_frame_len", 32'(fl0), 32'd16);

        // output stalled for 10 cycles while streaming
        obs.delete(); ex.delete(); in_cnt[0] = 0;
        fork
            send(0, 32'h50, 4);
            begin
                ordy[0] = 1'b0;
                repeat (10) @(posedge clk);
                @(negedge clk);
                chk("t4_accepted", 32'(in_cnt[0]), 32'd2);
                chk("t4_tready", 32'(tready[0]), 32'd0);
                @(posedge clk); #1;
                ready_run(0, 16'hFFFF, 20);
            end
        join
        add_frame(32'h50, 4, 1'b1, 32'd4);
        compare(0, "t4");

        // pass-through instance
        obs.delete(); ex.delete();
        fork
            send(1, 32'h30, 3);
            ready_run(1, 16'hFFFF, 10);
        join
        add_frame(32'h30, 3, 1'b0, 32'd0);
        compare(1, "t5");
        chk("t5_frame_len", 32'(fl1), 32'd3);

        // counter saturation on a 4-bit counter
        obs.delete(); ex.delete();
        fork
            send(2, 32'h0, 20);
            ready_run(2, 16'hFFFF, 30);
        join
        add_frame(32'h0, 20, 1'b1, 32'hF);
        compare(2, "t6");
        chk("t6_overflow", 32'(ovf[2]), 32'd1);
        chk("t6_frame_len", 32'(fl2), 32'hF);

        // reset in the middle of a frame
        tvalid[2] = 1'b1; tlast[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tdata[2] = 32'h60 + 32'(i);
            @(posedge clk); #1;
        end
        aresetn = 1'b0; tvalid[2] = 1'b0;
        @(negedge clk);
        chk_reset(2, "midrst");
        chk("midrst_fl2", 32'(fl2), 32'd0);
        @(posedge clk); #1;
        aresetn = 1'b1;
        obs.delete(); ex.delete();
        fork
            send(2, 32'h70, 2);
            ready_run(2, 16'hFFFF, 10);
        join
        add_frame(32'h70, 2, 1'b1, 32'd2);
        compare(2, "t7");
        chk("t7_frame_len", 32'(fl2), 32'd2);
        chk("t7_overflow", 32'(ovf[2]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
